// File: rtl/wave_clk_scheduler.sv
// rtl/wave_clk_scheduler.sv - run-bounded start/stop FSM driving fast/medium/slow divided waves
// Optional WAVE_PAUSE_EN adds a pause input that stalls the run while asserted.
module wave_clk_scheduler #(
  parameter int RUN_W     = 32,
  parameter int FAST_HALF = 1,
  parameter int MED_HALF  = 100,
  parameter int SLOW_HALF = 1000,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
`ifdef WAVE_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [RUN_W-1:0] run_len,
  output logic             busy,
  output logic             done,
  output logic             fast_out,
  output logic             medium_out,
  output logic             slow_out,
  output logic [RUN_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0][DIV_W-1:0] HALF_M1 = {DIV_W'(SLOW_HALF - 1),
                                                DIV_W'(MED_HALF - 1),
                                                DIV_W'(FAST_HALF - 1)};

  state_t                 state_q;
  logic [RUN_W-1:0]       len_q;
  logic [RUN_W-1:0]       cnt_q;
  logic [2:0][DIV_W-1:0]  div_q;
  logic [2:0][DIV_W-1:0]  div_d;
  logic [2:0]             wave_q;
  logic [2:0]             wave_d;
  logic                   busy_q;
  logic                   done_q;
  logic                   pause_w;
  logic                   last;
  logic                   step;

`ifdef WAVE_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // A stop on the terminal cycle still counts that cycle; otherwise stop freezes everything.
  assign last = (cnt_q == len_q - RUN_W'(1));
  assign step = (state_q == RUN) && (stop ? last : !pause_w);

  always_comb begin
    div_d  = div_q;
    wave_d = wave_q;
    for (int i = 0; i < 3; i++) begin
      if (div_q[i] == HALF_M1[i]) begin
        div_d[i]  = '0;
        wave_d[i] = ~wave_q[i];
      end else begin
        div_d[i] = div_q[i] + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      wave_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q  <= run_len;
            cnt_q  <= '0;
            div_q  <= '0;
            wave_q <= '0;
            if (run_len != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (step) begin
            cnt_q  <= cnt_q + RUN_W'(1);
            div_q  <= div_d;
            wave_q <= wave_d;
          end
          if (stop || (step && last)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          // Waves hold through DONE and drop on the way back to IDLE.
          state_q <= IDLE;
          div_q   <= '0;
          wave_q  <= '0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fast_out   = wave_q[0];
  assign medium_out = wave_q[1];
  assign slow_out   = wave_q[2];
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_wave_clk_scheduler.sv
// tb/tb_wave_clk_scheduler.sv - scoreboard bench for wave_clk_scheduler
module tb_wave_clk_scheduler;

  localparam int RUN_W = 32;
  localparam int FH    = 1;
  localparam int MH    = 2;
  localparam int SH    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [RUN_W-1:0] run_len;
  logic             busy;
  logic             done;
  logic             fast_out;
  logic             medium_out;
  logic             slow_out;
  logic [RUN_W-1:0] cycle_cnt;
`ifdef WAVE_PAUSE_EN
  logic             pause;
`endif

  always #5 clk = ~clk;

  wave_clk_scheduler #(
    .RUN_W(RUN_W), .FAST_HALF(FH), .MED_HALF(MH), .SLOW_HALF(SH), .DIV_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef WAVE_PAUSE_EN
    .pause(pause),
`endif
    .run_len(run_len), .busy(busy), .done(done), .fast_out(fast_out),
    .medium_out(medium_out), .slow_out(slow_out), .cycle_cnt(cycle_cnt)
  );

  typedef struct {
    int cnt;
    int busy_n;
    int tf;
    int tm;
    int ts;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: counts busy cycles and wave toggles, scores each done pulse against the queue.
  initial begin
    logic       prev_busy = 1'b0;
    logic [2:0] prev_w    = 3'b000;
    int         busy_n = 0, tf = 0, tm = 0, ts = 0, last_cnt = 0;
    bit         idle_chk = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (prev_busy) begin
        if (fast_out   !== prev_w[0]) tf++;
        if (medium_out !== prev_w[1]) tm++;
        if (slow_out   !== prev_w[2]) ts++;
      end
      if (busy === 1'b1) busy_n++;
      if (idle_chk) begin
        idle_chk = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_waves", {slow_out, medium_out, fast_out}, 0);
        check("idle_cnt_hold", cycle_cnt, last_cnt);
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 required 0");
        end else begin
          e = exp_q.pop_front();
          check("done_cycle_cnt", cycle_cnt, e.cnt);
          check("busy_cycles", busy_n, e.busy_n);
          check("fast_toggles", tf, e.tf);
          check("medium_toggles", tm, e.tm);
          check("slow_toggles", ts, e.ts);
          check("fast_level", fast_out, e.tf & 1);
          check("medium_level", medium_out, e.tm & 1);
          check("slow_level", slow_out, e.ts & 1);
          idle_chk = 1'b1;
          last_cnt = e.cnt;
        end
      end
      if (busy !== 1'b1 && done !== 1'b1) begin
        busy_n = 0; tf = 0; tm = 0; ts = 0;
      end
      prev_busy = busy;
      prev_w    = {slow_out, medium_out, fast_out};
    end
  end

  // L: run length; S: run cycle at which stop is pulsed (-1 none);
  // pause of pl cycles when the count reaches pc; noise: stray starts during RUN;
  // ss: stop pulsed together with start in IDLE.
  task automatic run_one(input int L, input int S, input int pc, input int pl,
                         input bit noise, input bit ss);
    exp_t e;
    int   c     = 0;
    int   pleft = pl;
    bit   running;
    bit   pz;
    bit   stopped;
    bit   phit = (pl > 0) && (L > 0) && (S < 0 || pc <= S);
    e.cnt    = (L == 0) ? 0 : ((S < 0 || S == L - 1) ? L : S);
    e.busy_n = (L == 0) ? 0 : (((S < 0) ? L : S + 1) + (phit ? pl : 0));
    e.tf     = e.cnt / FH;
    e.tm     = e.cnt / MH;
    e.ts     = e.cnt / SH;
    exp_q.push_back(e);
    start   = 1'b1;
    run_len = RUN_W'(L);
    stop    = ss;
    tick();
    start   = 1'b0;
    stop    = 1'b0;
    run_len = $urandom;
    running = (L != 0);
    while (running) begin
      pz      = 1'b0;
      stopped = 1'b0;
      if (pl > 0 && c == pc && pleft > 0) begin
        pz = 1'b1;
        pleft--;
      end else if (c == S) begin
        stop    = 1'b1;
        stopped = 1'b1;
      end
      if (noise && $urandom_range(3) == 0) begin
        start   = 1'b1;
        run_len = RUN_W'($urandom_range(1, 50));
      end
`ifdef WAVE_PAUSE_EN
      pause = pz;
`endif
      tick();
      if (stopped) running = 1'b0;
      else if (!pz) begin
        c++;
        if (c == L) running = 1'b0;
      end
      stop  = 1'b0;
      start = 1'b0;
`ifdef WAVE_PAUSE_EN
      pause = 1'b0;
`endif
    end
    tick();
  endtask

  task automatic run_reset(input int L, input int at);
    start   = 1'b1;
    run_len = RUN_W'(L);
    tick();
    start = 1'b0;
    repeat (at) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_waves", {slow_out, medium_out, fast_out}, 0);
    check("rst_cnt", cycle_cnt, 0);
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int L, S, pc, pl;
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    run_len = '0;
`ifdef WAVE_PAUSE_EN
    pause   = 1'b0;
`endif
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_fast", fast_out, 0);
    check("reset_medium", medium_out, 0);
    check("reset_slow", slow_out, 0);
    check("reset_cnt", cycle_cnt, 0);
    rst = 1'b0;
    tick();

    run_one(10, -1, 0, 0, 1'b0, 1'b0);
    run_one(0, -1, 0, 0, 1'b0, 1'b0);
    run_one(100, 4, 0, 0, 1'b0, 1'b0);
    run_one(12, -1, 0, 0, 1'b1, 1'b0);
    run_one(8, -1, 0, 0, 1'b0, 1'b1);
    run_one(6, 5, 0, 0, 1'b0, 1'b0);
    run_reset(20, 7);
    run_one(10, -1, 0, 0, 1'b0, 1'b0);
`ifdef WAVE_PAUSE_EN
    run_one(10, -1, 5, 3, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      L  = $urandom_range(0, 40);
      S  = (L > 0 && $urandom_range(2) == 0) ? $urandom_range(0, L - 1) : -1;
      pc = (L > 0) ? $urandom_range(0, L - 1) : 0;
      pl = 0;
`ifdef WAVE_PAUSE_EN
      pl = $urandom_range(0, 3);
`endif
      run_one(L, S, pc, pl, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
